// File: rtl/lc3_mem_if_pkg.sv
// Shared types and helpers for the LC-3 memory-access unit.
package lc3_pkg;

  typedef enum logic [1:0] {IDLE, PTR, ACC, RESP} mem_state_t;

  // A zero TIMEOUT still needs a one-bit counter so the RTL elaborates.
  function automatic int wait_cnt_width(input int timeout);
    int w;
    w = $clog2(timeout + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/lc3_mem_if_if.sv
// CPU request/response bus and memory req/ack bus for the LC-3 memory unit.
interface lc3_cpu_bus #(parameter int ADDR_W = 16, parameter int DATA_W = 16);
  logic              cpu_req_valid;
  logic              cpu_req_ready;
  logic              cpu_req_we;
  logic              cpu_req_indirect;
  logic [ADDR_W-1:0] cpu_req_addr;
  logic [DATA_W-1:0] cpu_req_wdata;
  logic              cpu_rsp_valid;
  logic [DATA_W-1:0] cpu_rsp_rdata;
  logic              cpu_rsp_err;

  modport master (output cpu_req_valid, cpu_req_we, cpu_req_indirect, cpu_req_addr, cpu_req_wdata,
                  input  cpu_req_ready, cpu_rsp_valid, cpu_rsp_rdata, cpu_rsp_err);
  modport slave  (input  cpu_req_valid, cpu_req_we, cpu_req_indirect, cpu_req_addr, cpu_req_wdata,
                  output cpu_req_ready, cpu_rsp_valid, cpu_rsp_rdata, cpu_rsp_err);
endinterface

interface lc3_mem_bus #(parameter int ADDR_W = 16, parameter int DATA_W = 16);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (output mem_req, mem_we, mem_addr, mem_wdata, input  mem_ack, mem_rdata);
  modport slave  (input  mem_req, mem_we, mem_addr, mem_wdata, output mem_ack, mem_rdata);
endinterface

// File: rtl/lc3_mem_if_wait_timer.sv
// Per-phase wait counter; expired flags the last allowed cycle of a phase.
module lc3_wait_timer
  import lc3_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = wait_cnt_width(TIMEOUT);
  localparam logic [CW-1:0] LIMIT = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      count <= '0;
    else if (clear)
      count <= '0;
    else if (enable && (TIMEOUT != 0))
      count <= count + 1'b1;
  end

  assign expired = (TIMEOUT != 0) && (count == LIMIT);

endmodule

// File: rtl/lc3_mem_if.sv
// LC-3 memory-access unit: owns MAR/MDR, handles direct and indirect
// (pointer fetch then access) transfers with a per-phase timeout.
module lc3_mem_if
  import lc3_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  lc3_cpu_bus.slave         cpu,
  lc3_mem_bus.master        mem,
  output logic [ADDR_W-1:0] mar,
  output logic [DATA_W-1:0] mdr
);

  generate
    if (ADDR_W > DATA_W) begin : g_width_check
      $error("lc3_mem_if: ADDR_W must not exceed DATA_W");
    end
  endgenerate

  mem_state_t        state, state_next;
  logic [ADDR_W-1:0] mar_next;
  logic [DATA_W-1:0] mdr_next;
  logic              we_q, we_next;
  logic              err_q, err_next;
  logic              timer_clear;
  logic              expired;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      mar   <= '0;
      mdr   <= '0;
      we_q  <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state <= state_next;
      mar   <= mar_next;
      mdr   <= mdr_next;
      we_q  <= we_next;
      err_q <= err_next;
    end
  end

  // An ack on the expiry edge still completes the phase; ack is checked first.
  always_comb begin
    state_next  = state;
    mar_next    = mar;
    mdr_next    = mdr;
    we_next     = we_q;
    err_next    = err_q;
    timer_clear = 1'b0;
    case (state)
      IDLE: begin
        if (cpu.cpu_req_valid) begin
          mar_next    = cpu.cpu_req_addr;
          if (cpu.cpu_req_we)
            mdr_next  = cpu.cpu_req_wdata;
          we_next     = cpu.cpu_req_we;
          err_next    = 1'b0;
          timer_clear = 1'b1;
          state_next  = cpu.cpu_req_indirect ? PTR : ACC;
        end
      end
      PTR: begin
        if (mem.mem_ack) begin
          mar_next    = mem.mem_rdata[ADDR_W-1:0];
          timer_clear = 1'b1;
          state_next  = ACC;
        end else if (expired) begin
          err_next    = 1'b1;
          state_next  = RESP;
        end
      end
      ACC: begin
        if (mem.mem_ack) begin
          if (!we_q)
            mdr_next  = mem.mem_rdata;
          state_next  = RESP;
        end else if (expired) begin
          err_next    = 1'b1;
          state_next  = RESP;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  lc3_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (timer_clear),
    .enable  (mem.mem_req && !mem.mem_ack),
    .expired (expired)
  );

  assign mem.mem_req       = (state == PTR) || (state == ACC);
  assign mem.mem_we        = (state == ACC) && we_q;
  assign mem.mem_addr      = mar;
  assign mem.mem_wdata     = mdr;

  assign cpu.cpu_req_ready = (state == IDLE) && !reset;
  assign cpu.cpu_rsp_valid = (state == RESP);
  assign cpu.cpu_rsp_err   = (state == RESP) && err_q;
  assign cpu.cpu_rsp_rdata = ((state == RESP) && !err_q) ? mdr : '0;

endmodule

// File: tb/tb_lc3_mem_if.sv
// Scoreboard bench for lc3_mem_if against a variable-latency memory model.
module tb_lc3_mem_if;
  import lc3_pkg::*;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic reset;
  logic [AW-1:0] mar;
  logic [DW-1:0] mdr;

  always #5 clk = ~clk;

  lc3_cpu_bus #(.ADDR_W(AW), .DATA_W(DW)) cpu ();
  lc3_mem_bus #(.ADDR_W(AW), .DATA_W(DW)) mem ();

  lc3_mem_if #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .cpu   (cpu),
    .mem   (mem),
    .mar   (mar),
    .mdr   (mdr)
  );

  typedef struct { logic [DW-1:0] rdata; logic err; } rsp_t;
  typedef struct { logic [AW-1:0] addr; logic we; logic [DW-1:0] wdata; } phase_t;
  typedef struct { logic req; logic we; logic [AW-1:0] addr; logic [DW-1:0] wdata; } trace_t;

  rsp_t   sb[$];
  phase_t plog[$];
  trace_t trace[$];
  int     total = 0;
  int     bad = 0;

  logic [DW-1:0] mem_arr [0:65535];
  int  wait_cfg = 0;
  bit  ack_en = 1'b1;
  bit  force_ack = 1'b0;
  int  phase_cnt = 0;

  // Memory model: ack after wait_cfg extra cycles, each phase counted from its first req cycle.
  always @(posedge clk) begin
    if (mem.mem_req && mem.mem_ack) begin
      if (mem.mem_we)
        mem_arr[mem.mem_addr] <= mem.mem_wdata;
      plog.push_back('{mem.mem_addr, mem.mem_we, mem.mem_wdata});
      phase_cnt <= 0;
    end else if (mem.mem_req) begin
      phase_cnt <= phase_cnt + 1;
    end else begin
      phase_cnt <= 0;
    end
  end

  always @(negedge clk) begin
    mem.mem_ack   <= (mem.mem_req && ack_en && (phase_cnt == wait_cfg)) || force_ack;
    mem.mem_rdata <= mem_arr[mem.mem_addr];
  end

  // Response scoreboard
  always @(negedge clk) begin
    if (cpu.cpu_rsp_valid) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("[TB] FAIL unexpected_rsp: got rdata=%h err=%0d, required no response", cpu.cpu_rsp_rdata, cpu.cpu_rsp_err);
      end else begin
        rsp_t e;
        e = sb.pop_front();
        if (cpu.cpu_rsp_rdata !== e.rdata || cpu.cpu_rsp_err !== e.err) begin
          bad++;
          $display("[TB] FAIL rsp_data: got rdata=%h err=%0d, required rdata=%h err=%0d",
                   cpu.cpu_rsp_rdata, cpu.cpu_rsp_err, e.rdata, e.err);
        end
      end
    end
  end

  task automatic send(input logic we, input logic ind, input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    cpu.cpu_req_valid    = 1'b1;
    cpu.cpu_req_we       = we;
    cpu.cpu_req_indirect = ind;
    cpu.cpu_req_addr     = a;
    cpu.cpu_req_wdata    = d;
    @(posedge clk);
    #1 cpu.cpu_req_valid = 1'b0;
  endtask

  // Counts negedges from the accept edge to the response cycle, tracing the memory bus meanwhile.
  task automatic wait_rsp(output int n, output bit got);
    n = 0;
    got = 1'b0;
    trace.delete();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n++;
      if (cpu.cpu_rsp_valid) begin
        got = 1'b1;
        break;
      end
      trace.push_back('{mem.mem_req, mem.mem_we, mem.mem_addr, mem.mem_wdata});
    end
  endtask

  function automatic int req_cycles();
    int c = 0;
    foreach (trace[i]) if (trace[i].req) c++;
    return c;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    #1;
    total++;
    if (cpu.cpu_req_ready !== 1'b0 || mem.mem_req !== 1'b0 || mem.mem_we !== 1'b0 ||
        cpu.cpu_rsp_valid !== 1'b0 || cpu.cpu_rsp_err !== 1'b0 || cpu.cpu_rsp_rdata !== '0 ||
        mar !== '0 || mdr !== '0) begin
      bad++;
      $display("[TB] FAIL reset_values: ready=%0d req=%0d we=%0d rv=%0d err=%0d rdata=%h mar=%h mdr=%h, required all 0",
               cpu.cpu_req_ready, mem.mem_req, mem.mem_we, cpu.cpu_rsp_valid, cpu.cpu_rsp_err, cpu.cpu_rsp_rdata, mar, mdr);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    total++;
    if (cpu.cpu_req_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL ready_after_reset: got %0d, required 1", cpu.cpu_req_ready);
    end
  endtask

  task automatic test_direct_read();
    int n; bit got;
    plog.delete();
    wait_cfg = 0;
    mem_arr[16'h3000] = 16'h1234;
    sb.push_back('{16'h1234, 1'b0});
    send(1'b0, 1'b0, 16'h3000, 16'h0000);
    wait_rsp(n, got);
    total++;
    if (!got || n !== 2) begin
      bad++;
      $display("[TB] FAIL direct_read_latency: got=%0d cycles=%0d, required 2", got, n);
    end
    total++;
    if (mar !== 16'h3000 || plog.size() !== 1) begin
      bad++;
      $display("[TB] FAIL direct_read_mar: mar=%h phases=%0d, required 3000 and 1", mar, plog.size());
    end
  endtask

  task automatic test_direct_write_wait();
    int n; bit got; int badcyc = 0;
    plog.delete();
    wait_cfg = 2;
    sb.push_back('{16'hBEEF, 1'b0});
    send(1'b1, 1'b0, 16'h4000, 16'hBEEF);
    wait_rsp(n, got);
    foreach (trace[i])
      if (trace[i].req && (trace[i].we !== 1'b1 || trace[i].wdata !== 16'hBEEF || trace[i].addr !== 16'h4000)) badcyc++;
    total++;
    if (!got || n !== 4 || req_cycles() !== 3 || badcyc !== 0) begin
      bad++;
      $display("[TB] FAIL write_wait: got=%0d cycles=%0d req_cycles=%0d unstable=%0d, required 1/4/3/0",
               got, n, req_cycles(), badcyc);
    end
    total++;
    if (mem_arr[16'h4000] !== 16'hBEEF) begin
      bad++;
      $display("[TB] FAIL write_mem: got %h, required beef", mem_arr[16'h4000]);
    end
  endtask

  task automatic test_ldi();
    int n; bit got;
    plog.delete();
    wait_cfg = 0;
    mem_arr[16'h3010] = 16'h5000;
    mem_arr[16'h5000] = 16'hAAAA;
    sb.push_back('{16'hAAAA, 1'b0});
    send(1'b0, 1'b1, 16'h3010, 16'h0000);
    wait_rsp(n, got);
    total++;
    if (!got || n !== 3) begin
      bad++;
      $display("[TB] FAIL ldi_latency: got=%0d cycles=%0d, required 3", got, n);
    end
    total++;
    if (plog.size() !== 2 || mar !== 16'h5000) begin
      bad++;
      $display("[TB] FAIL ldi_phases: phases=%0d mar=%h, required 2 and 5000", plog.size(), mar);
    end else begin
      total++;
      if (plog[0].addr !== 16'h3010 || plog[0].we !== 1'b0 || plog[1].addr !== 16'h5000 || plog[1].we !== 1'b0) begin
        bad++;
        $display("[TB] FAIL ldi_addrs: p0=%h/%0d p1=%h/%0d, required 3010/0 5000/0",
                 plog[0].addr, plog[0].we, plog[1].addr, plog[1].we);
      end
    end
  endtask

  task automatic test_sti();
    int n; bit got; int badcyc = 0;
    plog.delete();
    wait_cfg = 0;
    mem_arr[16'h3020] = 16'h6000;
    sb.push_back('{16'h0F0F, 1'b0});
    send(1'b1, 1'b1, 16'h3020, 16'h0F0F);
    wait_rsp(n, got);
    foreach (trace[i])
      if (trace[i].req && (trace[i].wdata !== 16'h0F0F || (trace[i].addr == 16'h3020 && trace[i].we !== 1'b0))) badcyc++;
    total++;
    if (!got || n !== 3 || badcyc !== 0 || mdr !== 16'h0F0F) begin
      bad++;
      $display("[TB] FAIL sti_flow: got=%0d cycles=%0d bad_cycles=%0d mdr=%h, required 1/3/0/0f0f", got, n, badcyc, mdr);
    end
    total++;
    if (plog.size() !== 2 || mem_arr[16'h6000] !== 16'h0F0F) begin
      bad++;
      $display("[TB] FAIL sti_mem: phases=%0d mem=%h, required 2 and 0f0f", plog.size(), mem_arr[16'h6000]);
    end else begin
      total++;
      if (plog[0].addr !== 16'h3020 || plog[0].we !== 1'b0 || plog[1].addr !== 16'h6000 || plog[1].we !== 1'b1) begin
        bad++;
        $display("[TB] FAIL sti_addrs: p0=%h/%0d p1=%h/%0d, required 3020/0 6000/1",
                 plog[0].addr, plog[0].we, plog[1].addr, plog[1].we);
      end
    end
  endtask

  task automatic test_timeout();
    int n; bit got; int stray = 0;
    ack_en = 1'b0;
    sb.push_back('{16'h0000, 1'b1});
    send(1'b0, 1'b0, 16'h7000, 16'h0000);
    wait_rsp(n, got);
    total++;
    if (!got || n !== 5 || req_cycles() !== TO) begin
      bad++;
      $display("[TB] FAIL timeout_acc: got=%0d cycles=%0d req_cycles=%0d, required 1/5/%0d", got, n, req_cycles(), TO);
    end
    force_ack = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (cpu.cpu_rsp_valid !== 1'b0 || mem.mem_req !== 1'b0) stray++;
    end
    force_ack = 1'b0;
    @(negedge clk);
    total++;
    if (stray !== 0 || cpu.cpu_req_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL late_ack: stray=%0d ready=%0d, required 0 and 1", stray, cpu.cpu_req_ready);
    end
    plog.delete();
    sb.push_back('{16'h0000, 1'b1});
    send(1'b0, 1'b1, 16'h7010, 16'h0000);
    wait_rsp(n, got);
    total++;
    if (!got || n !== 5 || req_cycles() !== TO || plog.size() !== 0) begin
      bad++;
      $display("[TB] FAIL timeout_ptr: got=%0d cycles=%0d req_cycles=%0d phases=%0d, required 1/5/%0d/0",
               got, n, req_cycles(), plog.size(), TO);
    end
    ack_en = 1'b1;
  endtask

  task automatic test_ack_at_limit();
    int n; bit got;
    wait_cfg = TO - 1;
    mem_arr[16'h7100] = 16'h55AA;
    sb.push_back('{16'h55AA, 1'b0});
    send(1'b0, 1'b0, 16'h7100, 16'h0000);
    wait_rsp(n, got);
    total++;
    if (!got || n !== 5 || req_cycles() !== TO) begin
      bad++;
      $display("[TB] FAIL ack_at_limit: got=%0d cycles=%0d req_cycles=%0d, required 1/5/%0d", got, n, req_cycles(), TO);
    end
    wait_cfg = 0;
  endtask

  task automatic test_reset_mid();
    wait_cfg = 10;
    send(1'b0, 1'b0, 16'h7200, 16'h0000);
    @(negedge clk);
    total++;
    if (mem.mem_req !== 1'b1) begin
      bad++;
      $display("[TB] FAIL mid_req_before_reset: got %0d, required 1", mem.mem_req);
    end
    #2 reset = 1'b1;
    #1;
    total++;
    if (mem.mem_req !== 1'b0 || cpu.cpu_req_ready !== 1'b0 || cpu.cpu_rsp_valid !== 1'b0 || mar !== '0 || mdr !== '0) begin
      bad++;
      $display("[TB] FAIL mid_reset: req=%0d ready=%0d rv=%0d mar=%h mdr=%h, required 0/0/0/0/0",
               mem.mem_req, cpu.cpu_req_ready, cpu.cpu_rsp_valid, mar, mdr);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    wait_cfg = 0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int n; bit got;
    mem_arr[16'h3000] = 16'h1234;
    mem_arr[16'h3001] = 16'h9876;
    sb.push_back('{16'h1234, 1'b0});
    send(1'b0, 1'b0, 16'h3000, 16'h0000);
    wait_rsp(n, got);
    sb.push_back('{16'h9876, 1'b0});
    send(1'b0, 1'b0, 16'h3001, 16'h0000);
    wait_rsp(n, got);
    total++;
    if (!got || n !== 2 || mar !== 16'h3001) begin
      bad++;
      $display("[TB] FAIL back_to_back: got=%0d cycles=%0d mar=%h, required 1/2/3001", got, n, mar);
    end
    @(negedge clk);
    total++;
    if (sb.size() !== 0) begin
      bad++;
      $display("[TB] FAIL scoreboard_drain: %0d responses outstanding, required 0", sb.size());
    end
  endtask

  initial begin
    cpu.cpu_req_valid    = 1'b0;
    cpu.cpu_req_we       = 1'b0;
    cpu.cpu_req_indirect = 1'b0;
    cpu.cpu_req_addr     = '0;
    cpu.cpu_req_wdata    = '0;
    mem.mem_ack          = 1'b0;
    mem.mem_rdata        = '0;
    for (int i = 0; i < 65536; i++) mem_arr[i] = '0;
    test_reset();
    test_direct_read();
    test_direct_write_wait();
    test_ldi();
    test_sti();
    test_timeout();
    test_ack_at_limit();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
